filter_sched: RTL and testbench

FILTER_SCHED -- requirements
Module: filter_sched

---
 rtl/filter_sched.sv | 164 ++++++++++++++++
 tb/tb_filter_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sched.sv
`default_nettype none
// filter_sched: one multiplier/accumulator time-shared by two requesters running a 3rd-order IIR (rev 1.0).
// Define FILTER_SCHED_CH1_EN for two-channel operation; otherwise only channel 0 is served.
module filter_sched #(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic signed [6:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic signed [6:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic              out_ch,
  output logic signed [6:0] out_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, WB = 2'd2} state_t;

  localparam logic signed [31:0] A0 = 32'sd16384;
  localparam logic signed [31:0] A1 = -32'sd47115;
  localparam logic signed [31:0] A2 = 32'sd45220;
  localparam logic signed [31:0] A3 = 32'sd14484;
  // Feedback coefficients are held negated so every MAC step is a plain add.
  localparam logic signed [31:0] NB1 = 32'sd44;
  localparam logic signed [31:0] NB2 = 32'sd44;
  localparam logic signed [31:0] NB3 = -32'sd46;

  state_t                   state, state_nx;
  logic [2:0]               step;
  logic                     last, cur_ch, grant, grant_ok, v0, v1;
  logic signed [6:0]        d1;
  logic signed [COEF_W-1:0] x0, hx1, hx2, hx3;
  logic signed [31:0]       hy1, hy2, hy3, mul_c, mul_d, y0;
  logic signed [ACC_W-1:0]  acc;
  logic signed [6:0]        sat;

`ifdef FILTER_SCHED_CH1_EN
  localparam int NCH = 2;
  assign v1        = in1_valid;
  assign d1        = in1_data;
  assign in1_ready = grant_ok && grant;
`else
  localparam int NCH = 1;
  logic unused_ch1;
  assign unused_ch1 = ^{in1_valid, in1_data};
  assign v1         = 1'b0;
  assign d1         = '0;
  assign in1_ready  = 1'b0;
`endif

  logic signed [COEF_W-1:0] xh [NCH][3];
  logic signed [31:0]       yh [NCH][3];

  assign v0 = in0_valid;

  always_comb begin
    grant = 1'b0;
    if (v0 && v1) grant = ~last;
    else if (v1)  grant = 1'b1;
    grant_ok = (v0 || v1) && (state == IDLE) && reset;
  end

  assign in0_ready = grant_ok && !grant;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_ok) state_nx = MAC;
      MAC:     if (step == 3'd6) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hx1 = '0; hx2 = '0; hx3 = '0;
    hy1 = '0; hy2 = '0; hy3 = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c == int'(cur_ch)) begin
        hx1 = xh[c][0]; hx2 = xh[c][1]; hx3 = xh[c][2];
        hy1 = yh[c][0]; hy2 = yh[c][1]; hy3 = yh[c][2];
      end
    end
    case (step)
      3'd0:    begin mul_c = A0;  mul_d = 32'(x0);  end
      3'd1:    begin mul_c = A1;  mul_d = 32'(hx1); end
      3'd2:    begin mul_c = A2;  mul_d = 32'(hx2); end
      3'd3:    begin mul_c = A3;  mul_d = 32'(hx3); end
      3'd4:    begin mul_c = NB1; mul_d = hy1;      end
      3'd5:    begin mul_c = NB2; mul_d = hy2;      end
      default: begin mul_c = NB3; mul_d = hy3;      end
    endcase
  end

  assign y0 = $signed(acc[31:0]) >>> 14;

  // Symmetric saturation: -64 is never emitted.
  always_comb begin
    if (y0 > 32'sd63)       sat = 7'sd63;
    else if (y0 < -32'sd63) sat = -7'sd63;
    else                    sat = y0[6:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      step      <= '0;
      last      <= 1'b1;
      cur_ch    <= 1'b0;
      x0        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < 3; j++) begin
          xh[c][j] <= '0;
          yh[c][j] <= '0;
        end
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            acc    <= '0;
            step   <= '0;
            cur_ch <= grant;
            last   <= grant;
            x0     <= grant ? COEF_W'(d1) : COEF_W'(in0_data);
          end
        end
        MAC: begin
          acc  <= acc + ACC_W'(mul_c) * ACC_W'(mul_d);
          step <= step + 3'd1;
        end
        WB: begin
          out_valid <= 1'b1;
          out_ch    <= cur_ch;
          out_data  <= sat;
          for (int c = 0; c < NCH; c++) begin
            if (c == int'(cur_ch)) begin
              xh[c][2] <= xh[c][1];
              xh[c][1] <= xh[c][0];
              xh[c][0] <= x0;
              yh[c][2] <= yh[c][1];
              yh[c][1] <= yh[c][0];
              yh[c][0] <= y0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_filter_sched.sv
`default_nettype none
// tb_filter_sched: randomized and directed stimulus against a behavioural IIR/arbiter model.
module tb_filter_sched;
  logic              clk = 1'b0;
  logic              reset;
  logic              in0_valid, in1_valid;
  logic signed [6:0] in0_data, in1_data;
  logic              in0_ready, in1_ready;
  logic              out_valid, out_ch;
  logic signed [6:0] out_data;

  filter_sched dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int data; int due; } res_t;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  res_t pend[$];
  res_t res_q[$];
  bit   mvalid = 0;
  int   mlast, next_ok, exp_ch, exp_data;
  int   mxh [2][3];
  int   myh [2][3];
  longint ca [4] = '{16384, -47115, 45220, 14484};
  longint cb [3] = '{-44, -44, 46};

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, k, got, want);
    end
  endtask

  // Direct-form IIR from the coefficient lists; histories kept in plain arrays.
  function automatic int model_sample(int c, int x);
    longint acc;
    int y;
    acc = ca[0] * x;
    for (int i = 0; i < 3; i++) acc += ca[i+1] * mxh[c][i] - cb[i] * myh[c][i];
    y = int'(acc) >>> 14;
    mxh[c][2] = mxh[c][1]; mxh[c][1] = mxh[c][0]; mxh[c][0] = x;
    myh[c][2] = myh[c][1]; myh[c][1] = myh[c][0]; myh[c][0] = y;
    return (y > 63) ? 63 : (y < -63) ? -63 : y;
  endfunction

  initial begin : monitor
    int v0, v1, g, any, er0, er1;
    bit ev;
    res_t r;
    forever begin
      @(negedge clk);
      k++;
      if (mvalid) begin
        ev = (pend.size() > 0) && (pend[0].due == k);
        chk("out_valid", int'(out_valid), int'(ev));
        if (ev) begin
          exp_ch   = pend[0].ch;
          exp_data = pend[0].data;
          void'(pend.pop_front());
        end
        chk("out_ch", int'(out_ch), exp_ch);
        chk("out_data", int'(out_data), exp_data);
      end
      if (out_valid === 1'b1) begin
        r.ch = int'(out_ch); r.data = int'(out_data); r.due = k;
        res_q.push_back(r);
      end
      if (reset === 1'b0) begin
        pend.delete();
        mxh = '{default: '{default: 0}};
        myh = '{default: '{default: 0}};
        mlast = 1; next_ok = 0; exp_ch = 0; exp_data = 0;
        mvalid = 1;
        chk("in0_ready_rst", int'(in0_ready), 0);
        chk("in1_ready_rst", int'(in1_ready), 0);
      end else if (mvalid) begin
        v0 = int'(in0_valid);
`ifdef FILTER_SCHED_CH1_EN
        v1 = int'(in1_valid);
`else
        v1 = 0;
`endif
        any = (k >= next_ok) && (v0 || v1);
        g   = (v0 && v1) ? 1 - mlast : v1;
        er0 = any && (g == 0);
        er1 = any && (g == 1);
        chk("in0_ready", int'(in0_ready), er0);
        chk("in1_ready", int'(in1_ready), er1);
        if (any) begin
          r.ch   = g;
          r.data = model_sample(g, (g == 0) ? int'(in0_data) : int'(in1_data));
          r.due  = k + 9;
          pend.push_back(r);
          next_ok = k + 9;
          mlast   = g;
        end
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send(input int ch, input int x);
    int n = 0;
    @(posedge clk); #1;
    if (ch == 0) begin in0_valid = 1'b1; in0_data = 7'(x); end
    else         begin in1_valid = 1'b1; in1_data = 7'(x); end
    do begin @(negedge clk); n++; end
    while (!((ch == 0) ? in0_ready : in1_ready) && n < 50);
    if (n >= 50) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int wch, input int wdata, input int wlat);
    int n = 0;
    res_t r;
    while (res_q.size() == 0 && n < 40) begin @(negedge clk); #1; n++; end
    if (res_q.size() == 0) chk({name, "_timeout"}, 0, 1);
    else begin
      r = res_q.pop_front();
      chk({name, "_ch"}, r.ch, wch);
      chk({name, "_data"}, r.data, wdata);
      if (wlat > 0) chk({name, "_latency"}, n, wlat);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    reset = 1'b1;

    // Single unit sample: result after 8 edges.
    res_q.delete();
    send(0, 1);
    wait_result("unit", 0, 1, 9);
    repeat (4) @(posedge clk);

    // 63 twice: 63, then raw -118 saturated to -63.
    do_reset(2);
    res_q.delete();
    send(0, 63);
    wait_result("sat_first", 0, 63, 9);
    send(0, 63);
    wait_result("sat_second", 0, -63, 9);

    // Reset during MAC step 3 must abort and clear history.
    do_reset(2);
    res_q.delete();
    send(0, 63);
    wait_result("pre_abort", 0, 63, 0);
    send(0, 20);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    chk("abort_no_result", res_q.size(), 0);
    send(0, 63);
    wait_result("post_abort", 0, 63, 9);

`ifdef FILTER_SCHED_CH1_EN
    // Both requesters held from reset release: strict alternation, 9 cycles apart.
    begin
      int gch [4];
      int gk  [4];
      int ng = 0, n = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      in0_valid = 1'b1; in0_data = 7'sd10;
      in1_valid = 1'b1; in1_data = -7'sd10;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      while (ng < 4 && n < 60) begin
        @(negedge clk); n++;
        if (in0_ready) begin gch[ng] = 0; gk[ng] = n; ng++; end
        else if (in1_ready) begin gch[ng] = 1; gk[ng] = n; ng++; end
      end
      chk("rr_count", ng, 4);
      for (int i = 0; i < ng; i++) chk("rr_order", gch[i], i % 2);
      for (int i = 1; i < ng; i++) chk("rr_spacing", gk[i] - gk[i-1], 9);
      @(posedge clk); #1;
      in0_valid = 1'b0; in1_valid = 1'b0;
      repeat (20) @(posedge clk);
    end

    // Channel isolation: ch1 traffic between ch0 samples 1 and 0.
    do_reset(2);
    res_q.delete();
    send(0, 1);
    wait_result("iso_a", 0, 1, 9);
    send(1, 63);
    wait_result("iso_ch1", 1, 63, 9);
    send(0, 0);
    // floor((-47115 + 44) / 16384) = -3
    wait_result("iso_b", 0, -3, 9);
`else
    // Channel 1 disabled: its request is ignored entirely.
    do_reset(2);
    res_q.delete();
    @(posedge clk); #1;
    in1_valid = 1'b1; in1_data = 7'sd33;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("ch1_disabled_ready", int'(in1_ready), 0);
    end
    @(posedge clk); #1;
    in1_valid = 1'b0;
    repeat (10) @(posedge clk);
    chk("ch1_disabled_no_result", res_q.size(), 0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 399) != 0);
      in0_valid = ($urandom_range(0, 3) != 0);
      in0_data  = 7'($urandom);
      in1_valid = ($urandom_range(0, 2) != 0);
      in1_data  = 7'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("drain_pending", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
